// File: rtl/lfsr_decrypt_engine.sv
// Stream-cipher receiver: recovers LFSR seed and taps from the space preamble,
// then decrypts the ciphertext block, strips leading pads and writes the message.
module lfsr_decrypt_engine #(
  parameter logic [7:0] CT_BASE  = 8'd64,
  parameter int         CT_LEN   = 64,
  parameter logic [7:0] MSG_BASE = 8'd0,
  parameter int         MSG_LEN  = 41,
  parameter int         PRE_MIN  = 9,
  parameter logic [7:0] PAD      = 8'h20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       done,
  output logic       err,
  output logic [7:0] key_ptrn,
  output logic [7:0] key_init
);

  localparam int DATA_W = 8;
  localparam logic [6:0] I_PRE  = 7'(PRE_MIN);
  localparam logic [6:0] I_LAST = 7'(CT_LEN - 1);
  localparam logic [6:0] O_MAX  = 7'(MSG_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_SEED, S_TRAIN, S_RESOLVE, S_DECRYPT, S_FILL, S_DONE
  } state_t;

  function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] s,
                                                  input logic [DATA_W-1:0] p);
    return {s[DATA_W-2:0], ^(s & p)};
  endfunction

  function automatic logic [DATA_W-1:0] pat(input logic [2:0] j);
    case (j)
      3'd0:    return 8'hE1;
      3'd1:    return 8'hD4;
      3'd2:    return 8'hC6;
      3'd3:    return 8'hB8;
      3'd4:    return 8'hB4;
      3'd5:    return 8'hB2;
      3'd6:    return 8'hFA;
      default: return 8'hF3;
    endcase
  endfunction

  state_t            state_q, state_d;
  logic [6:0]        i_q, i_d, o_q, o_d, i_inc;
  logic [DATA_W-1:0] s_q, s_d, mask_q, mask_d, rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] key_ptrn_q, key_ptrn_d, key_init_q, key_init_d;
  logic              found_q, found_d, done_q, done_d, err_q, err_d;
  logic [DATA_W-1:0] k, s_nxt, plain;
  logic [2:0]        low;

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    o_d        = o_q;
    s_d        = s_q;
    mask_d     = mask_q;
    found_d    = found_q;
    key_ptrn_d = key_ptrn_q;
    key_init_d = key_init_q;
    done_d     = done_q;
    err_d      = err_q;
    rd_addr_d  = rd_addr_q;
    wr_en      = 1'b0;
    wr_addr    = 8'h00;
    wr_data    = 8'h00;
    i_inc      = i_q + 7'd1;
    k          = rd_data ^ PAD;
    s_nxt      = lfsr_next(s_q, key_ptrn_q);
    plain      = rd_data ^ s_nxt;
    low        = 3'd0;
    for (int j = 7; j >= 0; j--) if (mask_q[j]) low = 3'(j);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          done_d    = 1'b0;
          err_d     = 1'b0;
          mask_d    = 8'hFF;
          found_d   = 1'b0;
          o_d       = 7'd0;
          i_d       = 7'd0;
          rd_addr_d = CT_BASE;
          state_d   = S_REQ;
        end
      end
      // rd_addr is on the bus this cycle; pick the capture state by byte index
      S_REQ: begin
        if (i_q == 7'd0)      state_d = S_SEED;
        else if (i_q < I_PRE) state_d = S_TRAIN;
        else                  state_d = S_DECRYPT;
      end
      S_SEED: begin
        s_d        = k;
        key_init_d = k;
        if (k == 8'h00) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          i_d       = i_inc;
          rd_addr_d = CT_BASE + 8'(i_inc);
          state_d   = S_REQ;
        end
      end
      S_TRAIN: begin
        for (int j = 0; j < 8; j++)
          if (lfsr_next(s_q, pat(3'(j))) != k) mask_d[j] = 1'b0;
        s_d = k;
        if (i_q == I_PRE - 7'd1) begin
          state_d = S_RESOLVE;
        end else begin
          i_d       = i_inc;
          rd_addr_d = CT_BASE + 8'(i_inc);
          state_d   = S_REQ;
        end
      end
      S_RESOLVE: begin
        if (mask_q == 8'h00) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          key_ptrn_d = pat(low);
          i_d        = I_PRE;
          rd_addr_d  = CT_BASE + 8'(I_PRE);
          state_d    = S_REQ;
        end
      end
      S_DECRYPT: begin
        s_d = s_nxt;
        if (found_q || plain != PAD) begin
          wr_en   = 1'b1;
          wr_addr = MSG_BASE + 8'(o_q);
          wr_data = plain;
          found_d = 1'b1;
          o_d     = o_q + 7'd1;
        end
        // stop reading once the output region is full
        if (i_q == I_LAST || o_d == O_MAX) begin
          state_d = S_FILL;
        end else begin
          i_d       = i_inc;
          rd_addr_d = CT_BASE + 8'(i_inc);
          state_d   = S_REQ;
        end
      end
      S_FILL: begin
        if (o_q < O_MAX) begin
          wr_en   = 1'b1;
          wr_addr = MSG_BASE + 8'(o_q);
          wr_data = PAD;
          o_d     = o_q + 7'd1;
        end else begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      i_q        <= 7'd0;
      o_q        <= 7'd0;
      s_q        <= 8'h00;
      mask_q     <= 8'h00;
      found_q    <= 1'b0;
      key_ptrn_q <= 8'h00;
      key_init_q <= 8'h00;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_addr_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      o_q        <= o_d;
      s_q        <= s_d;
      mask_q     <= mask_d;
      found_q    <= found_d;
      key_ptrn_q <= key_ptrn_d;
      key_init_q <= key_init_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rd_addr_q  <= rd_addr_d;
    end
  end

  assign rd_addr  = rd_addr_q;
  assign done     = done_q;
  assign err      = err_q;
  assign key_ptrn = key_ptrn_q;
  assign key_init = key_init_q;

endmodule

// File: tb/tb_lfsr_decrypt_engine.sv
// Directed bench for lfsr_decrypt_engine: encrypts known messages into a memory
// model, runs the decryptor and compares keys, flags and the plaintext region.
module tb_lfsr_decrypt_engine;

  localparam logic [7:0] PAD = 8'h20;

  logic       clk = 1'b0;
  logic       reset, start, clr;
  logic [7:0] rd_addr, rd_data, rd_q, wr_addr, wr_data, key_ptrn, key_init;
  logic       wr_en, done, err;

  lfsr_decrypt_engine dut (
    .clk(clk), .reset(reset), .start(start),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .done(done), .err(err), .key_ptrn(key_ptrn), .key_init(key_init)
  );

  always #5 clk = ~clk;

  logic [7:0] ct_mem  [64];
  logic [7:0] out_mem [256];
  int         wr_cnt  [256];
  int         wr_total, wr_stray;

  always @(posedge clk) begin
    rd_q <= (rd_addr[7:6] == 2'b01) ? ct_mem[rd_addr[5:0]] : 8'h00;
    if (clr) begin
      for (int a = 0; a < 256; a++) begin
        out_mem[a] <= 8'hAA;
        wr_cnt[a]  <= 0;
      end
      wr_total <= 0;
      wr_stray <= 0;
    end else if (wr_en) begin
      wr_total         <= wr_total + 1;
      out_mem[wr_addr] <= wr_data;
      wr_cnt[wr_addr]  <= wr_cnt[wr_addr] + 1;
      if (wr_addr > 8'd40) wr_stray <= wr_stray + 1;
    end
  end
  assign rd_data = rd_q;

  logic [7:0] PATS [8] = '{8'hE1, 8'hD4, 8'hC6, 8'hB8, 8'hB4, 8'hB2, 8'hFA, 8'hF3};

  typedef struct {
    logic [7:0] ptrn;
    logic [7:0] init;
    int         pre;
    int         msg;
    int         corrupt;   // 0 none, 1 force seed byte to zero key, 2 flip bit 7 of ct[5]
    bit         restart;   // pulse start again while busy
    bit         exp_err;
    logic [7:0] exp_key;
  } vec_t;

  vec_t  vecs[$];
  string msgs[3];

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0] exp_mem [41];
  logic       m_err;
  logic [7:0] m_key;

  function automatic logic [7:0] nxt(input logic [7:0] s, input logic [7:0] p);
    return {s[6:0], ^(s & p)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic encrypt(input vec_t v);
    logic [7:0] s, p;
    string m;
    int idx;
    m = msgs[v.msg];
    s = v.init;
    for (int i = 0; i < 64; i++) begin
      idx = i - v.pre;
      p = (i < v.pre || idx >= m.len()) ? PAD : m[idx];
      ct_mem[i] = p ^ s;
      s = nxt(s, v.ptrn);
    end
    if (v.corrupt == 1) ct_mem[0] = PAD;
    if (v.corrupt == 2) ct_mem[5] = ct_mem[5] ^ 8'h80;
  endtask

  // reference decryptor built straight from the algorithm description
  task automatic model();
    logic [7:0] s, k, p, mask;
    int o;
    bit found;
    m_err = 1'b0;
    m_key = 8'h00;
    for (int a = 0; a < 41; a++) exp_mem[a] = 8'hAA;
    s = ct_mem[0] ^ PAD;
    if (s == 8'h00) begin
      m_err = 1'b1;
      return;
    end
    mask = 8'hFF;
    for (int i = 1; i < 9; i++) begin
      k = ct_mem[i] ^ PAD;
      for (int j = 0; j < 8; j++) if (nxt(s, PATS[j]) != k) mask[j] = 1'b0;
      s = k;
    end
    if (mask == 8'h00) begin
      m_err = 1'b1;
      return;
    end
    for (int j = 7; j >= 0; j--) if (mask[j]) m_key = PATS[j];
    o = 0;
    found = 1'b0;
    for (int i = 9; i < 64 && o < 41; i++) begin
      s = nxt(s, m_key);
      p = ct_mem[i] ^ s;
      if (found || p != PAD) begin
        found = 1'b1;
        exp_mem[o] = p;
        o++;
      end
    end
    while (o < 41) begin
      exp_mem[o] = PAD;
      o++;
    end
  endtask

  task automatic run_vec(input vec_t v, input int tag);
    int cycles, nbad, first, wbad;
    encrypt(v);
    model();
    @(negedge clk) clr = 1'b1;
    @(negedge clk) begin
      clr   = 1'b0;
      start = 1'b1;
    end
    @(negedge clk) start = 1'b0;
    chk($sformatf("v%0d_done_cleared", tag), {63'd0, done}, 64'd0);
    cycles = 1;
    while (!done && cycles < 250) begin
      start = (v.restart && cycles == 30);
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    chk($sformatf("v%0d_done", tag), {63'd0, done}, 64'd1);
    chk($sformatf("v%0d_latency_le_200", tag), {63'd0, (cycles <= 200)}, 64'd1);
    chk($sformatf("v%0d_err", tag), {63'd0, err}, {63'd0, v.exp_err});
    chk($sformatf("v%0d_model_err", tag), {63'd0, err}, {63'd0, m_err});
    chk($sformatf("v%0d_key_init", tag), {56'd0, key_init},
        {56'd0, (v.corrupt == 1) ? 8'h00 : v.init});
    if (!v.exp_err) begin
      chk($sformatf("v%0d_key_ptrn", tag), {56'd0, key_ptrn}, {56'd0, v.exp_key});
      chk($sformatf("v%0d_key_model", tag), {56'd0, key_ptrn}, {56'd0, m_key});
    end
    nbad = 0;
    first = -1;
    for (int a = 0; a < 41; a++)
      if (out_mem[a] !== exp_mem[a]) begin
        nbad++;
        if (first < 0) first = a;
      end
    if (first >= 0)
      $display("  v%0d first differing byte at %0d: got %0h expected %0h",
               tag, first, out_mem[first], exp_mem[first]);
    chk($sformatf("v%0d_mem_bad_bytes", tag), 64'(nbad), 64'd0);
    wbad = 0;
    for (int a = 0; a < 41; a++) if (wr_cnt[a] != (v.exp_err ? 0 : 1)) wbad++;
    chk($sformatf("v%0d_write_once_bad", tag), 64'(wbad + wr_stray), 64'd0);
    if (v.exp_err) chk($sformatf("v%0d_no_writes", tag), 64'(wr_total), 64'd0);
  endtask

  initial begin
    int w0;
    vec_t v;
    msgs[0] = "Knowledge comes, but wisdom lingers.     ";
    msgs[1] = "";
    for (int i = 0; i < 27; i++) msgs[1] = {msgs[1], " "};
    msgs[1] = {msgs[1], "Ajok"};
    msgs[2] = "";

    vecs.push_back('{8'hB4, 8'h5A, 9, 0, 0, 1'b0, 1'b0, 8'hB4});
    vecs.push_back('{8'hFA, 8'h08 | 8'($urandom_range(255)), 10, 1, 0, 1'b0, 1'b0, 8'hFA});
    vecs.push_back('{8'hB4, 8'h5A, 9, 0, 1, 1'b0, 1'b1, 8'h00});
    vecs.push_back('{8'hB4, 8'h5A, 9, 0, 2, 1'b0, 1'b1, 8'h00});
    vecs.push_back('{8'hD4, 8'h3C, 12, 0, 0, 1'b1, 1'b0, 8'hD4});
    vecs.push_back('{8'hE1, 8'h77, 9, 2, 0, 1'b0, 1'b0, 8'hE1});
    for (int j = 0; j < 8; j++) begin
      vecs.push_back('{PATS[j], 8'h01, 9, 0, 0, 1'b0, 1'b0, PATS[j]});
      vecs.push_back('{PATS[j], 8'hFF, 9, 0, 0, 1'b0, 1'b0, PATS[j]});
    end

    reset = 1'b1;
    start = 1'b0;
    clr   = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {rd_addr, wr_en, wr_addr, wr_data, done, err, key_ptrn, key_init}, 64'd0);
    reset = 1'b0;
    clr   = 1'b0;
    @(negedge clk);
    chk("idle_outputs", {rd_addr, wr_en, wr_addr, wr_data, done, err, key_ptrn, key_init}, 64'd0);

    foreach (vecs[n]) run_vec(vecs[n], n);

    // reset in the middle of the decrypt phase, then a clean run
    v = vecs[0];
    encrypt(v);
    @(negedge clk) clr = 1'b1;
    @(negedge clk) begin
      clr   = 1'b0;
      start = 1'b1;
    end
    @(negedge clk) start = 1'b0;
    repeat (40) @(negedge clk);
    chk("midrun_writes_started", {63'd0, (wr_total > 0)}, 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_outputs", {rd_addr, wr_en, wr_addr, wr_data, done, err, key_ptrn, key_init}, 64'd0);
    @(negedge clk) reset = 1'b0;
    w0 = wr_total;
    repeat (5) @(negedge clk);
    chk("no_write_after_reset", 64'(wr_total), 64'(w0));
    chk("idle_after_reset_done", {63'd0, done}, 64'd0);
    run_vec(v, 100);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
